rs232_line_parser: RTL and testbench

//  Parametrised line-buffered command parser between the UART RX byte stream and the UART TX burst sender.

---
 rtl/rs232_line_parser_if.sv | 21 ++
 rtl/rs232_line_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_rs232_line_parser.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_line_parser_if.sv
// rtl/rs232_line_parser_if.sv - rx byte stream and tx burst handshake bundle for the line parser
interface rs232_line_parser_if #(
    parameter int TX_MAX_BYTES = 8
);
    logic [7:0]                rx_byte;
    logic                      rx_valid;
    logic                      tx_ready;
    logic [TX_MAX_BYTES*8-1:0] tx_bytes;
    logic [3:0]                tx_num_bytes;
    logic                      tx_valid;

    modport master (
        output rx_byte, rx_valid, tx_ready,
        input  tx_bytes, tx_num_bytes, tx_valid
    );

    modport slave (
        input  rx_byte, rx_valid, tx_ready,
        output tx_bytes, tx_num_bytes, tx_valid
    );
endinterface

// File: rtl/rs232_line_parser.sv
// rtl/rs232_line_parser.sv - line-buffered UART command parser with keyword and hex-argument decode
module rs232_line_parser #(
    parameter int MAX_BYTES    = 8,
    parameter int TX_MAX_BYTES = 8,
    parameter int ARG_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    rs232_line_parser_if.slave   bus,
    output logic [7:0]           command_valid,
    output logic                 rs_232_reset,
    output logic [ARG_WIDTH-1:0] arg_data,
    output logic                 arg_valid,
    output logic                 rx_overrun,
    output logic                 busy
);
    localparam int         TXW          = TX_MAX_BYTES * 8;
    localparam logic [3:0] MAX_COUNT    = 4'(MAX_BYTES);
    localparam logic [3:0] WR_MAX_COUNT = 4'(3 + ARG_WIDTH / 4);

    localparam logic [7:0] CODE_CMD   = 8'h01;
    localparam logic [7:0] CODE_RESET = 8'h02;
    localparam logic [7:0] CODE_WR    = 8'h03;
    localparam logic [7:0] CODE_ERR   = 8'hFF;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [39:0] TXT_RESP = 40'h72_65_73_70_0D;
    localparam logic [23:0] TXT_OK   = 24'h6F_6B_0D;
    localparam logic [31:0] TXT_ERR  = 32'h65_72_72_0D;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_MATCH,
        S_ARG,
        S_ERR,
        S_RESP
    } state_t;

    state_t state, state_next;

    // Sixteen slots so the 4-bit count indexes without truncation; slots at or
    // beyond MAX_BYTES are never written and stay at their reset value.
    logic [7:0]           line_buf [16];
    logic [3:0]           count;
    logic                 ovf;
    logic [3:0]           idx;
    logic [ARG_WIDTH-1:0] acc;
    logic                 rx_valid_q;
    logic [TXW-1:0]       tx_bytes_r;
    logic [3:0]           tx_num_r;

    logic                 strobe;
    logic                 line_cmd;
    logic                 line_reset;
    logic                 line_wr;
    logic [7:0]           digit;
    logic                 hex_ok;
    logic [3:0]           hex_val;
    logic                 last_digit;
    logic [ARG_WIDTH-1:0] acc_next;

    always_comb begin
        strobe     = bus.rx_valid & ~rx_valid_q;

        line_cmd   = (count == 4'd3)
                   && (line_buf[0] == "c") && (line_buf[1] == "m") && (line_buf[2] == "d");
        line_reset = (count == 4'd5)
                   && (line_buf[0] == "r") && (line_buf[1] == "e") && (line_buf[2] == "s")
                   && (line_buf[3] == "e") && (line_buf[4] == "t");
        line_wr    = (count >= 4'd4) && (count <= WR_MAX_COUNT)
                   && (line_buf[0] == "w") && (line_buf[1] == "r") && (line_buf[2] == " ");

        digit   = line_buf[idx];
        hex_ok  = 1'b0;
        hex_val = 4'd0;
        if (digit >= "0" && digit <= "9") begin
            hex_ok  = 1'b1;
            hex_val = digit[3:0];
        end else if ((digit >= "a" && digit <= "f") || (digit >= "A" && digit <= "F")) begin
            // Low nibble of a..f / A..F is 1..6, so adding 9 yields 10..15.
            hex_ok  = 1'b1;
            hex_val = digit[3:0] + 4'd9;
        end

        last_digit = (idx == count - 4'd1);
        acc_next   = {acc[ARG_WIDTH-5:0], hex_val};

        state_next = state;
        case (state)
            S_COLLECT: begin
                if (strobe && bus.rx_byte == CH_CR && (count != 4'd0 || ovf)) begin
                    state_next = S_MATCH;
                end
            end
            S_MATCH: begin
                if (ovf) begin
                    state_next = S_ERR;
                end else if (line_cmd) begin
                    state_next = S_RESP;
                end else if (line_reset) begin
                    state_next = S_COLLECT;
                end else if (line_wr) begin
                    state_next = S_ARG;
                end else begin
                    state_next = S_ERR;
                end
            end
            S_ARG: begin
                if (!hex_ok) begin
                    state_next = S_ERR;
                end else if (last_digit) begin
                    state_next = S_RESP;
                end
            end
            S_ERR: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (bus.tx_ready) begin
                    state_next = S_COLLECT;
                end
            end
            default: begin
                state_next = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_COLLECT;
            for (int i = 0; i < 16; i++) begin
                line_buf[i] <= 8'h00;
            end
            count         <= 4'd0;
            ovf           <= 1'b0;
            idx           <= 4'd0;
            acc           <= '0;
            rx_valid_q    <= 1'b0;
            tx_bytes_r    <= '0;
            tx_num_r      <= 4'd0;
            command_valid <= 8'h00;
            rs_232_reset  <= 1'b0;
            arg_data      <= '0;
            arg_valid     <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            state        <= state_next;
            rx_valid_q   <= bus.rx_valid;
            rs_232_reset <= 1'b0;
            arg_valid    <= 1'b0;

            if (strobe && state != S_COLLECT) begin
                rx_overrun <= 1'b1;
            end

            case (state)
                S_COLLECT: begin
                    if (strobe) begin
                        if (bus.rx_byte == CH_BS) begin
                            // Any removal leaves count below MAX_BYTES, so overflow is forgiven.
                            if (count != 4'd0) begin
                                count <= count - 4'd1;
                                ovf   <= 1'b0;
                            end
                        end else if (bus.rx_byte != CH_LF && bus.rx_byte != CH_CR) begin
                            if (count < MAX_COUNT) begin
                                line_buf[count] <= bus.rx_byte;
                                count           <= count + 4'd1;
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                    end
                end
                S_MATCH: begin
                    if (!ovf) begin
                        if (line_cmd) begin
                            command_valid <= CODE_CMD;
                            tx_bytes_r    <= TXW'(TXT_RESP) << (TXW - 40);
                            tx_num_r      <= 4'd5;
                        end else if (line_reset) begin
                            command_valid <= CODE_RESET;
                            rs_232_reset  <= 1'b1;
                            count         <= 4'd0;
                        end else if (line_wr) begin
                            acc <= '0;
                            idx <= 4'd3;
                        end
                    end
                end
                S_ARG: begin
                    if (hex_ok) begin
                        acc <= acc_next;
                        idx <= idx + 4'd1;
                        if (last_digit) begin
                            arg_data      <= acc_next;
                            arg_valid     <= 1'b1;
                            command_valid <= CODE_WR;
                            tx_bytes_r    <= TXW'(TXT_OK) << (TXW - 24);
                            tx_num_r      <= 4'd3;
                        end
                    end
                end
                S_ERR: begin
                    command_valid <= CODE_ERR;
                    tx_bytes_r    <= TXW'(TXT_ERR) << (TXW - 32);
                    tx_num_r      <= 4'd4;
                end
                S_RESP: begin
                    if (bus.tx_ready) begin
                        count <= 4'd0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.tx_bytes     = tx_bytes_r;
    assign bus.tx_num_bytes = tx_num_r;
    assign bus.tx_valid     = (state == S_RESP);
    assign busy             = (state != S_COLLECT);

endmodule

// File: tb/tb_rs232_line_parser.sv
// tb/tb_rs232_line_parser.sv - directed-vector bench with a line-level reference model
module tb_rs232_line_parser;
    localparam int MAXB = 8;
    localparam int TXB  = 8;
    localparam int AW   = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    command_valid;
    logic          rs_232_reset;
    logic [AW-1:0] arg_data;
    logic          arg_valid;
    logic          rx_overrun;
    logic          busy;

    always #5 clock = ~clock;

    rs232_line_parser_if #(.TX_MAX_BYTES(TXB)) bus ();

    rs232_line_parser #(.MAX_BYTES(MAXB), .TX_MAX_BYTES(TXB), .ARG_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .command_valid(command_valid), .rs_232_reset(rs_232_reset),
        .arg_data(arg_data), .arg_valid(arg_valid),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    typedef struct {
        bit          is_reset;
        bit          is_wr;
        logic [63:0] bytes;
        int          n;
        logic [7:0]  code;
        logic [15:0] arg;
        int          cr_cyc;
        int          lat;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  mline[$];
    bit          movf;
    logic [15:0] model_arg;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pack(string s);
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < s.len(); i++) b[63-8*i -: 8] = s[i];
        return b;
    endfunction

    function automatic bit line_is(string s);
        if (mline.size() != s.len()) return 1'b0;
        for (int i = 0; i < s.len(); i++) if (mline[i] != s[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int hex_of(logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Decide the outcome of a completed line from its text alone.
    function automatic exp_t classify();
        exp_t e;
        int   v, h;
        bit   ok;
        e.is_reset = 0; e.is_wr = 0; e.cr_cyc = cyc; e.lat = -1;
        e.bytes = pack("err\015"); e.n = 4; e.code = 8'hFF; e.arg = model_arg;
        if (!movf) begin
            if (line_is("cmd")) begin
                e.bytes = pack("resp\015"); e.n = 5; e.code = 8'h01; e.lat = 2;
            end else if (line_is("reset")) begin
                e.is_reset = 1; e.code = 8'h02; e.lat = 2;
            end else if (mline.size() >= 4 && mline.size() <= 3 + AW/4
                         && mline[0] == "w" && mline[1] == "r" && mline[2] == " ") begin
                v = 0; ok = 1;
                for (int i = 3; i < mline.size(); i++) begin
                    h = hex_of(mline[i]);
                    if (h < 0) ok = 0;
                    else v = v * 16 + h;
                end
                if (ok) begin
                    e.is_wr = 1; e.arg = 16'(v); e.bytes = pack("ok\015"); e.n = 3;
                    e.code = 8'h03; e.lat = 2 + mline.size() - 3;
                end
            end
        end
        return e;
    endfunction

    task automatic model_byte(logic [7:0] c);
        exp_t e;
        if (c == 8'h0A) begin
        end else if (c == 8'h08) begin
            if (mline.size() > 0) begin
                void'(mline.pop_back());
                movf = 0;
            end
        end else if (c == 8'h0D) begin
            if (mline.size() != 0 || movf) begin
                e = classify();
                if (e.is_wr) model_arg = e.arg;
                expq.push_back(e);
            end
            mline.delete();
            movf = 0;
        end else if (mline.size() < MAXB) begin
            mline.push_back(c);
        end else begin
            movf = 1;
        end
    endtask

    task automatic send(logic [7:0] c, bit to_model);
        @(negedge clock);
        bus.rx_byte  = c;
        bus.rx_valid = 1'b1;
        if (to_model) model_byte(c);
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int t = 0;
        while (busy && t < 60) begin
            @(negedge clock);
            t++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic send_line(string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
        wait_idle({"idle_after_", s});
    endtask

    // Compare process: every response, reset pulse and argument update is
    // matched against the head of the model's expectation queue.
    initial begin
        exp_t cur;
        exp_t e;
        bit   tv_q = 0, rs_q = 0, av_q = 0, exp_fall = 0, arg_seen = 0;
        int   lat;
        forever begin
            @(negedge clock);
            if (reset) begin
                tv_q = 0; rs_q = 0; av_q = 0; exp_fall = 0; arg_seen = 0;
            end else begin
                if (exp_fall) begin
                    chk("tx_valid_single_cycle", bus.tx_valid, 1'b0);
                    exp_fall = 0;
                end
                if (rs_232_reset) begin
                    chk("rs_232_reset_width", rs_q, 1'b0);
                    if (expq.size() == 0) chk("reset_unexpected", 0, 1);
                    else if (!rs_q) begin
                        e = expq.pop_front();
                        chk("reset_kind", e.is_reset, 1'b1);
                        chk("reset_latency", cyc - e.cr_cyc, 2);
                        chk("reset_code", command_valid, 8'h02);
                        chk("reset_no_tx", bus.tx_valid, 1'b0);
                    end
                end
                if (arg_valid) begin
                    chk("arg_valid_width", av_q, 1'b0);
                    if (expq.size() == 0) chk("arg_unexpected", 0, 1);
                    else begin
                        chk("arg_kind", expq[0].is_wr, 1'b1);
                        chk("arg_data", arg_data, expq[0].arg);
                        arg_seen = 1;
                    end
                end
                if (bus.tx_valid && !tv_q) begin
                    if (expq.size() == 0) chk("tx_unexpected", 0, 1);
                    else begin
                        cur = expq.pop_front();
                        lat = cyc - cur.cr_cyc;
                        chk("tx_kind", cur.is_reset, 1'b0);
                        chk("tx_bytes", bus.tx_bytes, cur.bytes);
                        chk("tx_num_bytes", bus.tx_num_bytes, cur.n);
                        chk("command_valid", command_valid, cur.code);
                        if (cur.lat >= 0) chk("tx_latency", lat, cur.lat);
                        else chk("err_latency_bound", (lat >= 2 && lat <= 3 + MAXB), 1'b1);
                        if (cur.is_wr) chk("arg_pulse_seen", arg_seen, 1'b1);
                        else chk("arg_data_held", arg_data, cur.arg);
                        arg_seen = 0;
                        if (bus.tx_ready) exp_fall = 1;
                    end
                end else if (bus.tx_valid) begin
                    chk("tx_bytes_stable", bus.tx_bytes, cur.bytes);
                end
                tv_q = bus.tx_valid;
                rs_q = rs_232_reset;
                av_q = arg_valid;
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
        movf = 0; model_arg = 16'h0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_num", bus.tx_num_bytes, 4'd0);
        chk("rst_tx_bytes", bus.tx_bytes, 64'h0);
        chk("rst_command_valid", command_valid, 8'h00);
        chk("rst_arg", {arg_valid, arg_data}, 17'h0);
        chk("rst_flags", {rs_232_reset, rx_overrun, busy}, 3'b000);
        reset = 1'b0;

        send_line("cmd\015");
        chk("lit_cmd_code", command_valid, 8'h01);
        chk("lit_cmd_text", bus.tx_bytes[63:24], 40'h72_65_73_70_0D);

        send_line("wr 1a2F\015");
        chk("lit_wr_arg", arg_data, 16'h1A2F);
        chk("lit_wr_code", command_valid, 8'h03);

        send_line("wr 12G\015");
        send_line("xyz\015");
        send_line("wr \015");
        chk("lit_err_arg_held", arg_data, 16'h1A2F);
        chk("lit_err_code", command_valid, 8'hFF);

        send_line("abcdefghi\015");
        send_line("cmx\010d\015");
        send_line("\015");
        chk("lit_empty_keeps_code", command_valid, 8'h01);
        send_line("c\012md\015");
        send_line("\010\010cmd\015");
        send_line("cmdxxxxxyy\010\010\010\010\010\015");
        send_line("abcdefgh\015");
        send_line("wr 12345\015");
        send_line("wr 9\015");
        chk("lit_wr_one_digit", arg_data, 16'h0009);
        send_line("wr ffff\015");
        send_line("CMD\015");

        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i == 3 ? 8'h0D : (i == 0 ? 8'h63 : (i == 1 ? 8'h6D : 8'h64)), 1'b1);
        t = 0;
        while (!bus.tx_valid && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("overrun_tx_pending", bus.tx_valid, 1'b1);
        send("a", 1'b0);
        @(negedge clock);
        chk("overrun_flag", rx_overrun, 1'b1);
        chk("overrun_tx_held", bus.tx_valid, 1'b1);
        bus.tx_ready = 1'b1;
        wait_idle("overrun_release");
        chk("overrun_tx_cleared", bus.tx_valid, 1'b0);
        send_line("cmd\015");
        chk("overrun_sticky", rx_overrun, 1'b1);

        send_line("reset\015");
        chk("lit_reset_code", command_valid, 8'h02);

        send("c", 1'b1);
        send("m", 1'b1);
        reset = 1'b1;
        mline.delete(); movf = 0; expq.delete(); model_arg = 16'h0;
        @(negedge clock);
        chk("midline_rst_overrun", rx_overrun, 1'b0);
        chk("midline_rst_code", command_valid, 8'h00);
        reset = 1'b0;
        send_line("d\015");
        chk("lit_after_reset_code", command_valid, 8'hFF);

        repeat (4) @(negedge clock);
        chk("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
